// File: rtl/lspc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lspc_pkg
// Description : Shared constants and types for the LSPC raster timer.
// Revision    : 1.0 - initial release
// ============================================================================
package lspc_pkg;

    localparam int ACK_RESET = 0;
    localparam int ACK_TIMER = 1;
    localparam int ACK_VBL   = 2;

    localparam int TM_RELOAD_WR   = 0;
    localparam int TM_RELOAD_VBL  = 1;
    localparam int TM_RELOAD_ZERO = 2;

    localparam logic [31:0] c_count_reset = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_LOAD = 2'd1,
        CNT_ZERO = 2'd2,
        CNT_DEC  = 2'd3
    } cnt_src_e;

endpackage : lspc_pkg
`default_nettype wire

// File: rtl/lspc_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : lspc_timer_if
// Description : Register-decoder side of the timer: CPU data, write strobes
//               and latched mode fields.
// Revision    : 1.0 - initial release
// ============================================================================
interface lspc_timer_if;

    logic [15:0] M68K_DATA;
    logic        WR_TIMER_HIGH;
    logic        WR_TIMER_LOW;
    logic        WR_IRQ_ACK;
    logic [2:0]  TIMER_MODE;
    logic        TIMER_IRQ_EN;
    logic        TIMER_STOP;

    modport master (
        output M68K_DATA, WR_TIMER_HIGH, WR_TIMER_LOW, WR_IRQ_ACK,
        output TIMER_MODE, TIMER_IRQ_EN, TIMER_STOP
    );

    modport slave (
        input M68K_DATA, WR_TIMER_HIGH, WR_TIMER_LOW, WR_IRQ_ACK,
        input TIMER_MODE, TIMER_IRQ_EN, TIMER_STOP
    );

endinterface : lspc_timer_if
`default_nettype wire

// File: rtl/lspc_strobe_sync.sv
`default_nettype none
// ============================================================================
// Module      : lspc_strobe_sync
// Description : Synchronises an active-low async strobe and emits a one-cycle
//               pulse on its synchronised falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module lspc_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_strobe_n,
    output logic      o_write
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_prev;
    logic                   r_armed;

    // r_fill marks when the last stage holds a real sample rather than the
    // reset value, so a strobe held low across reset release is never taken
    // as a falling edge: a genuine high level must be observed first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '1;
            r_fill  <= '0;
            r_prev  <= 1'b1;
            r_armed <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_strobe_n};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_prev <= r_sync[SYNC_STAGES-1];
            if (r_fill[SYNC_STAGES-1] && r_sync[SYNC_STAGES-1]) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_write = r_armed & r_prev & ~r_sync[SYNC_STAGES-1];

endmodule : lspc_strobe_sync
`default_nettype wire

// File: rtl/lspc_timer.sv
`default_nettype none
// ============================================================================
// Module      : lspc_timer
// Description : LSPC raster-interrupt down-counter and IRQ pending flags.
//               LSPC_TIMER_READBACK_EN builds the TIMER_COUNT readback reg.
// Revision    : 1.0 - initial release
// ============================================================================
module lspc_timer
    import lspc_pkg::*;
#(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [8:0] PAL_STOP_TOP = 9'h010,
    parameter logic [8:0] PAL_STOP_BOT = 9'h1F0
) (
    input  wire logic        CLK_24M,
    input  wire logic        RESET,
    input  wire logic        CLK_EN_6M,
    lspc_timer_if.slave      bus,
    input  wire logic        VMODE,
    input  wire logic [8:0]  RASTERC,
    input  wire logic        VBL_START,
    output logic             IRQ_TIMER,
    output logic             IRQ_VBL,
    output logic             TIMER_ZERO,
    output logic [31:0]      TIMER_COUNT
);

    logic        w_wr_high;
    logic        w_wr_low;
    logic        w_wr_ack;
    logic        w_hold;
    cnt_src_e    w_src;
    logic [31:0] w_cnt_next;

    logic [31:0] r_reload;
    logic        r_reload_req;
    logic [31:0] r_counter;
    logic        r_irq_timer;
    logic        r_irq_vbl;
    logic        r_zero;

    lspc_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_high (
        .clk(CLK_24M), .rst(RESET), .i_strobe_n(bus.WR_TIMER_HIGH), .o_write(w_wr_high)
    );
    lspc_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_low (
        .clk(CLK_24M), .rst(RESET), .i_strobe_n(bus.WR_TIMER_LOW), .o_write(w_wr_low)
    );
    lspc_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ack (
        .clk(CLK_24M), .rst(RESET), .i_strobe_n(bus.WR_IRQ_ACK), .o_write(w_wr_ack)
    );

    assign w_hold = VMODE & bus.TIMER_STOP &
                    ((RASTERC < PAL_STOP_TOP) | (RASTERC >= PAL_STOP_BOT));

    always_comb begin
        w_src = CNT_HOLD;
        if (CLK_EN_6M) begin
            if (r_reload_req) begin
                w_src = CNT_LOAD;
            end else if (VBL_START && bus.TIMER_MODE[TM_RELOAD_VBL]) begin
                w_src = CNT_LOAD;
            end else if (!w_hold) begin
                w_src = (r_counter == '0) ? CNT_ZERO : CNT_DEC;
            end
        end
    end

    always_comb begin
        w_cnt_next = r_counter;
        case (w_src)
            CNT_LOAD: w_cnt_next = r_reload;
            CNT_ZERO: w_cnt_next = bus.TIMER_MODE[TM_RELOAD_ZERO] ? r_reload : c_count_reset;
            CNT_DEC:  w_cnt_next = r_counter - 32'd1;
            default:  w_cnt_next = r_counter;
        endcase
    end

    // A low-word write landing on an enable cycle keeps its request, so the
    // load on the following enable always sees the complete new value.
    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            r_reload     <= '0;
            r_reload_req <= 1'b0;
            r_counter    <= c_count_reset;
            r_irq_timer  <= 1'b0;
            r_irq_vbl    <= 1'b0;
            r_zero       <= 1'b0;
        end else begin
            r_counter <= w_cnt_next;
            r_zero    <= (w_src == CNT_ZERO);

            if (w_wr_high) begin
                r_reload[31:16] <= bus.M68K_DATA;
            end
            if (w_wr_low) begin
                r_reload[15:0] <= bus.M68K_DATA;
            end

            if (w_wr_low && bus.TIMER_MODE[TM_RELOAD_WR]) begin
                r_reload_req <= 1'b1;
            end else if (CLK_EN_6M) begin
                r_reload_req <= 1'b0;
            end

            if ((w_src == CNT_ZERO) && bus.TIMER_IRQ_EN) begin
                r_irq_timer <= 1'b1;
            end else if (w_wr_ack && bus.M68K_DATA[ACK_TIMER]) begin
                r_irq_timer <= 1'b0;
            end

            if (VBL_START) begin
                r_irq_vbl <= 1'b1;
            end else if (w_wr_ack && bus.M68K_DATA[ACK_VBL]) begin
                r_irq_vbl <= 1'b0;
            end
        end
    end

    assign IRQ_TIMER  = r_irq_timer;
    assign IRQ_VBL    = r_irq_vbl;
    assign TIMER_ZERO = r_zero;

`ifdef LSPC_TIMER_READBACK_EN
    logic [31:0] r_count_rb;

    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            r_count_rb <= c_count_reset;
        end else begin
            r_count_rb <= r_counter;
        end
    end

    assign TIMER_COUNT = r_count_rb;
`else
    assign TIMER_COUNT = '0;
`endif

endmodule : lspc_timer
`default_nettype wire

// File: tb/tb_lspc_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lspc_timer
// Description : Self-checking bench for lspc_timer: cycle reference model,
//               directed scenarios and randomized register traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lspc_timer;

    localparam int N     = 2;
    localparam int K_HI  = 0;
    localparam int K_LO  = 1;
    localparam int K_ACK = 2;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       en     = 1'b0;
    logic       vbl    = 1'b0;
    logic       vmode  = 1'b0;
    logic [8:0] raster = 9'd0;
    wire        irq_t;
    wire        irq_v;
    wire        zero;
    wire [31:0] count;

    lspc_timer_if bus ();

    lspc_timer #(.SYNC_STAGES(N)) dut (
        .CLK_24M    (clk),
        .RESET      (rst),
        .CLK_EN_6M  (en),
        .bus        (bus),
        .VMODE      (vmode),
        .RASTERC    (raster),
        .VBL_START  (vbl),
        .IRQ_TIMER  (irq_t),
        .IRQ_VBL    (irq_v),
        .TIMER_ZERO (zero),
        .TIMER_COUNT(count)
    );

    int n_cmp     = 0;
    int n_err     = 0;
    int edge_cnt  = 0;
    int vbl_edge  = -1;
    int zcount    = 0;
    int last_fall = 0;

    typedef struct {
        int          at;
        int          kind;
        logic [15:0] d;
    } ev_t;
    ev_t evq[$];

    logic [31:0] m_reload, m_cnt, m_rb;
    logic        m_req, m_it, m_iv, m_zero;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Enable every 4th edge; VBL_START only on the requested enable edge.
    initial forever begin
        @(negedge clk);
        en  = ((edge_cnt + 1) % 4 == 0);
        vbl = en && (edge_cnt + 1 == vbl_edge);
    end

    // Reference model: the per-tick priority rules applied to plain variables.
    initial begin
        logic [31:0] old_reload;
        bit          hold, set_t, zev;
        m_reload = '0; m_cnt = '1; m_rb = '1;
        m_req = 0; m_it = 0; m_iv = 0; m_zero = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_reload = '0; m_cnt = '1; m_rb = '1;
                m_req = 0; m_it = 0; m_iv = 0; m_zero = 0;
                evq.delete();
            end else begin
                edge_cnt++;
                old_reload = m_reload;
                m_rb  = m_cnt;
                hold  = vmode && bus.TIMER_STOP && (raster < 9'h010 || raster >= 9'h1F0);
                set_t = 0;
                zev   = 0;
                if (en) begin
                    if (m_req) begin
                        m_cnt = old_reload;
                        m_req = 0;
                    end else if (vbl && bus.TIMER_MODE[1]) begin
                        m_cnt = old_reload;
                    end else if (!hold) begin
                        if (m_cnt == 0) begin
                            zev   = 1;
                            m_cnt = bus.TIMER_MODE[2] ? old_reload : 32'hFFFF_FFFF;
                            set_t = bus.TIMER_IRQ_EN;
                        end else begin
                            m_cnt = m_cnt - 1;
                        end
                    end
                end
                m_zero = zev;
                while (evq.size() > 0 && evq[0].at == edge_cnt) begin
                    case (evq[0].kind)
                        K_HI: m_reload[31:16] = evq[0].d;
                        K_LO: begin
                            m_reload[15:0] = evq[0].d;
                            if (bus.TIMER_MODE[0]) m_req = 1;
                        end
                        default: begin
                            if (evq[0].d[1]) m_it = 0;
                            if (evq[0].d[2]) m_iv = 0;
                        end
                    endcase
                    void'(evq.pop_front());
                end
                if (set_t) m_it = 1;
                if (vbl)   m_iv = 1;
            end
            #1;
            check("irq_timer", 32'(irq_t), 32'(m_it));
            check("irq_vbl", 32'(irq_v), 32'(m_iv));
            check("timer_zero", 32'(zero), 32'(m_zero));
`ifdef LSPC_TIMER_READBACK_EN
            check("timer_count", count, m_rb);
`else
            check("timer_count", count, 32'h0);
`endif
            if (zero === 1'b1) zcount++;
        end
    end

    task automatic strobe(input int kind, input logic [15:0] d, input bit with_vbl);
        if (with_vbl) begin
            do @(negedge clk); while ((edge_cnt + N + 1) % 4 != 0);
            vbl_edge = edge_cnt + N + 1;
        end else begin
            @(negedge clk);
        end
        bus.M68K_DATA = d;
        case (kind)
            K_HI:    bus.WR_TIMER_HIGH = 1'b0;
            K_LO:    bus.WR_TIMER_LOW  = 1'b0;
            default: bus.WR_IRQ_ACK    = 1'b0;
        endcase
        last_fall = edge_cnt;
        evq.push_back('{edge_cnt + N + 1, kind, d});
        repeat (N + 3) @(negedge clk);
        bus.WR_TIMER_HIGH = 1'b1;
        bus.WR_TIMER_LOW  = 1'b1;
        bus.WR_IRQ_ACK    = 1'b1;
        repeat (N + 3) @(negedge clk);
    endtask

    task automatic wait_zero(input int limit, output bit ok, output int at);
        ok = 0;
        at = -1;
        for (int i = 0; i < limit && !ok; i++) begin
            @(posedge clk);
            #2;
            if (zero === 1'b1) begin
                ok = 1;
                at = edge_cnt;
            end
        end
    endtask

    task automatic sched_vbl();
        vbl_edge = ((edge_cnt + 5) / 4) * 4;
    endtask

    task automatic window(input logic [8:0] r, input int exp, input string name);
        @(negedge clk);
        raster = r;
        zcount = 0;
        repeat (40) @(negedge clk);
        check(name, 32'(zcount), 32'(exp));
    endtask

    initial begin
        bit         ok;
        int         za, zb, lat_exp;
        logic [8:0] rl [7];
        rl = '{9'h000, 9'h008, 9'h00F, 9'h010, 9'h100, 9'h1EF, 9'h1F0};
        bus.M68K_DATA     = '0;
        bus.WR_TIMER_HIGH = 1'b1;
        bus.WR_TIMER_LOW  = 1'b1;
        bus.WR_IRQ_ACK    = 1'b1;
        bus.TIMER_MODE    = 3'b000;
        bus.TIMER_IRQ_EN  = 1'b0;
        bus.TIMER_STOP    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_irq_t", 32'(irq_t), 32'h0);
        check("rst_irq_v", 32'(irq_v), 32'h0);
        check("rst_zero", 32'(zero), 32'h0);
`ifdef LSPC_TIMER_READBACK_EN
        check("rst_count", count, 32'hFFFF_FFFF);
`endif
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Reload 3, no auto-reload: single zero event 4 ticks after the load.
        bus.TIMER_MODE   = 3'b001;
        bus.TIMER_IRQ_EN = 1'b1;
        strobe(K_HI, 16'h0000, 0);
        strobe(K_LO, 16'h0003, 0);
        lat_exp = ((last_fall + N + 1) / 4 + 1) * 4 + 16;
        wait_zero(60, ok, za);
        check("t1_zero_seen", 32'(ok), 32'h1);
        check("t1_zero_edge", 32'(za), 32'(lat_exp));
`ifdef LSPC_TIMER_READBACK_EN
        @(posedge clk); #2;
        check("t1_rb_wrap", count, 32'hFFFF_FFFF);
        repeat (4) @(posedge clk); #2;
        check("t1_rb_dec", count, 32'hFFFF_FFFE);
`endif
        check("t1_irq", 32'(irq_t), 32'h1);

        // Reload 2 with auto-reload: a zero event every 3 ticks.
        bus.TIMER_MODE = 3'b101;
        strobe(K_LO, 16'h0002, 0);
        wait_zero(60, ok, za);
        wait_zero(60, ok, zb);
        check("t2_zero_seen", 32'(ok), 32'h1);
        check("t2_period", 32'(zb - za), 32'd12);
        @(negedge clk);
        zcount = 0;
        repeat (120) @(negedge clk);
        check("t2_count", 32'(zcount), 32'd10);

        // PAL line stop with reload 0: zero every running tick, none when held.
        vmode          = 1'b1;
        bus.TIMER_STOP = 1'b1;
        raster         = 9'h008;
        strobe(K_LO, 16'h0000, 0);
        @(negedge clk);
        zcount = 0;
        repeat (400) @(negedge clk);
        check("t3_frozen", 32'(zcount), 32'd0);
`ifdef LSPC_TIMER_READBACK_EN
        check("t3_frozen_rb", count, 32'h0);
`endif
        window(9'h010, 10, "t3_run_top");
        window(9'h1EF, 10, "t3_run_bot");
        window(9'h1F0, 0, "t3_stop_bot");
        bus.TIMER_IRQ_EN = 1'b0;
        bus.TIMER_MODE   = 3'b000;
        bus.TIMER_STOP   = 1'b0;
        vmode            = 1'b0;
        raster           = 9'h000;

        // Acknowledge behaviour with both IRQs pending.
        @(negedge clk);
        sched_vbl();
        repeat (8) @(negedge clk);
        check("t4_pre_t", 32'(irq_t), 32'h1);
        check("t4_pre_v", 32'(irq_v), 32'h1);
        strobe(K_ACK, 16'h0002, 0);
        check("t4_ack_t", 32'(irq_t), 32'h0);
        check("t4_ack_t_keep_v", 32'(irq_v), 32'h1);
        strobe(K_ACK, 16'h0004, 1);
        check("t4_set_wins", 32'(irq_v), 32'h1);
        strobe(K_ACK, 16'h0001, 0);
        check("t4_bit0_ignored", 32'(irq_v), 32'h1);
        strobe(K_ACK, 16'h0004, 0);
        check("t4_ack_v", 32'(irq_v), 32'h0);

        // Reset with a low-word reload pending, strobe held low across release.
        bus.TIMER_MODE   = 3'b001;
        bus.TIMER_IRQ_EN = 1'b1;
        strobe(K_HI, 16'h0000, 0);
        sched_vbl();
        do @(negedge clk); while ((edge_cnt + N + 1) % 4 != 1);
        bus.M68K_DATA    = 16'h0005;
        bus.WR_TIMER_LOW = 1'b0;
        evq.push_back('{edge_cnt + N + 1, K_LO, 16'h0005});
        repeat (N + 1) @(negedge clk);
        check("t5_pre_v", 32'(irq_v), 32'h1);
        rst            = 1'b1;
        bus.TIMER_MODE = 3'b101;
        #1;
        check("t5_rst_irq_t", 32'(irq_t), 32'h0);
        check("t5_rst_irq_v", 32'(irq_v), 32'h0);
        check("t5_rst_zero", 32'(zero), 32'h0);
`ifdef LSPC_TIMER_READBACK_EN
        check("t5_rst_count", count, 32'hFFFF_FFFF);
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        bus.WR_TIMER_LOW = 1'b1;
        zcount = 0;
        repeat (80) @(negedge clk);
        check("t5_no_reload", 32'(zcount), 32'd0);
        check("t5_no_irq", 32'(irq_t), 32'h0);

        // Randomized register traffic against the model.
        for (int it = 0; it < 250; it++) begin
            int r;
            r = $urandom_range(0, 9);
            bus.TIMER_MODE   = 3'($urandom_range(0, 7));
            bus.TIMER_IRQ_EN = 1'($urandom_range(0, 1));
            bus.TIMER_STOP   = 1'($urandom_range(0, 1));
            vmode            = 1'($urandom_range(0, 1));
            raster           = rl[$urandom_range(0, 6)];
            if (r < 2)      strobe(K_HI, ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0, 0);
            else if (r < 5) strobe(K_LO, 16'($urandom_range(0, 12)), 0);
            else if (r < 7) strobe(K_ACK, 16'($urandom_range(0, 7)), 0);
            else if (r < 8) sched_vbl();
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_lspc_timer
`default_nettype wire
